usb_packet_bridge: RTL and testbench

Parametrised successor to the single-device USB register bridge. It sits between the FT245-style USB FIFO and the standard master bus. It parses framed host packets into bursts of bus reads or writes of configurable address and data width, buffering each burst in an internal word RAM. Writes are committed to the bus only after a valid trailer is received. Every packet gets a framed status response, with read data returned in the response.

---
 rtl/usb_packet_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_usb_packet_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_bridge.sv
// usb_packet_bridge: FT245 FIFO to master-bus bridge. Parses framed burst packets,
// buffers the words internally and answers every packet with a framed status response.
module usb_packet_bridge #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int BUF_DEPTH    = 256,
  parameter int BYTE_TIMEOUT = 65535,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              FT_RXFn,
  input  logic              FT_TXEn,
  output logic              FT_RDn,
  output logic              FT_WR,
  input  logic [7:0]        FT_DATA_In,
  output logic [7:0]        FT_DATA_Out,
  output logic              USB_Active,
  output logic              Header_recognized,
  output logic              Trailer_recognized,
  output logic              Packet_Proc,
  output logic              Error,
  output logic              AccessRequest,
  input  logic              AccessGranted,
  output logic              DirectOut,
  output logic [ADDR_W-1:0] AddrBusOut,
  output logic [DATA_W-1:0] DataBusOut,
  input  logic [DATA_W-1:0] DataBus_In,
  input  logic              DataBusStrobe
);
  localparam int NA  = ADDR_W / 8;
  localparam int NB  = DATA_W / 8;
  localparam int IW  = $clog2(BUF_DEPTH);
  localparam int BTW = $clog2(BYTE_TIMEOUT + 1) + 1;
  localparam int ATW = $clog2(ACK_TIMEOUT + 1) + 1;

  typedef enum logic [3:0] {
    S_HUNT, S_HDR2, S_CMD, S_CNT, S_ADDR, S_WDATA, S_TRL1, S_TRL2,
    S_BUS_REQ, S_BUS_XFER, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rd_ph_q, rd_ph_d;
  logic              rd_n_q, rd_n_d;
  logic [2:0]        wr_ph_q, wr_ph_d;
  logic              wr_q, wr_d;
  logic [7:0]        dout_q, dout_d;
  logic              hdr_q, hdr_d, trl_q, trl_d, err_q, err_d, wcmd_q, wcmd_d;
  logic [1:0]        status_q, status_d;
  logic [2:0]        rsel_q, rsel_d;
  logic [IW-1:0]     cnt_m1_q, cnt_m1_d, idx_q, idx_d, idx_nx;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0] wacc_q, wacc_d, data_q, data_d;
  logic [BTW-1:0]    tmo_q, tmo_d;
  logic [ATW-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic              mem_we;
  logic [IW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              byte_vld, rx_state, pkt_body;
  logic [7:0]        rx, tx_byte;
  logic [8:0]        cnt_val;

  assign rx       = FT_DATA_In;
  assign byte_vld = (rd_ph_q == 2'd2);
  assign rx_state = (state_q inside {S_HUNT, S_HDR2, S_CMD, S_CNT, S_ADDR, S_WDATA, S_TRL1, S_TRL2});
  assign pkt_body = (state_q inside {S_CMD, S_CNT, S_ADDR, S_WDATA, S_TRL1, S_TRL2});
  assign cnt_val  = {(rx == 8'd0), rx};
  assign idx_nx   = idx_q + 1'b1;

  // Response byte sequence: A5 5A STATUS [data words MSB first] 5A A5
  always_comb begin
    case (rsel_q)
      3'd0:    tx_byte = 8'hA5;
      3'd1:    tx_byte = 8'h5A;
      3'd2:    tx_byte = {6'd0, status_q};
      3'd3:    tx_byte = 8'(mem_q[idx_q] >> (8 * (NB - 1 - int'(bidx_q))));
      3'd4:    tx_byte = 8'h5A;
      default: tx_byte = 8'hA5;
    endcase
  end

  always_comb begin
    state_d = state_q;  rd_ph_d = rd_ph_q;  wr_ph_d = wr_ph_q;  dout_d = dout_q;
    hdr_d = 1'b0;  trl_d = 1'b0;  err_d = 1'b0;  wcmd_d = wcmd_q;  status_d = status_q;
    rsel_d = rsel_q;  cnt_m1_d = cnt_m1_q;  idx_d = idx_q;  bidx_d = bidx_q;
    base_d = base_q;  addr_d = addr_q;  wacc_d = wacc_q;  data_d = data_q;
    tmo_d = (pkt_body && !byte_vld) ? tmo_q + 1'b1 : '0;
    ack_d = ack_q + 1'b1;
    mem_we = 1'b0;  mem_wa = idx_q;  mem_wd = DataBus_In;

    // FIFO read: two low cycles, sample on the second, then at least one high cycle
    case (rd_ph_q)
      2'd0:    if (rx_state && !FT_RXFn) rd_ph_d = 2'd1;
      2'd1:    rd_ph_d = 2'd2;
      default: rd_ph_d = 2'd0;
    endcase

    // FIFO write: data setup, two strobe-high cycles, data hold
    case (wr_ph_q)
      3'd0: if (state_q == S_RESP && !FT_TXEn) begin
        dout_d  = tx_byte;
        wr_ph_d = 3'd1;
      end
      3'd4:    wr_ph_d = 3'd0;
      default: wr_ph_d = wr_ph_q + 3'd1;
    endcase

    case (state_q)
      S_HUNT: if (byte_vld && rx == 8'hA5) state_d = S_HDR2;
      S_HDR2: if (byte_vld) begin
        if (rx == 8'h5A) begin
          hdr_d   = 1'b1;
          state_d = S_CMD;
        end else if (rx != 8'hA5) state_d = S_HUNT;
      end
      S_CMD: if (byte_vld) begin
        wcmd_d   = rx[0];
        status_d = 2'd0;
        state_d  = S_CNT;
      end
      S_CNT: if (byte_vld) begin
        if (cnt_val > 9'(BUF_DEPTH)) begin
          err_d = 1'b1;  status_d = 2'd2;  idx_d = '0;  bidx_d = '0;  state_d = S_RESP;
        end else begin
          cnt_m1_d = IW'(cnt_val - 9'd1);
          bidx_d   = '0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: if (byte_vld) begin
        base_d = (base_q << 8) | ADDR_W'(rx);
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'(NA - 1)) begin
          bidx_d  = '0;
          idx_d   = '0;
          state_d = wcmd_q ? S_WDATA : S_TRL1;
        end
      end
      S_WDATA: if (byte_vld) begin
        wacc_d = (wacc_q << 8) | DATA_W'(rx);
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'(NB - 1)) begin
          bidx_d = '0;
          mem_we = 1'b1;
          mem_wd = (wacc_q << 8) | DATA_W'(rx);
          if (idx_q == cnt_m1_q) state_d = S_TRL1;
          else idx_d = idx_nx;
        end
      end
      S_TRL1: if (byte_vld) begin
        if (rx == 8'h5A) state_d = S_TRL2;
        else begin
          err_d = 1'b1;  status_d = 2'd3;  idx_d = '0;  bidx_d = '0;  state_d = S_RESP;
        end
      end
      S_TRL2: if (byte_vld) begin
        if (rx == 8'hA5) begin
          trl_d   = 1'b1;
          state_d = S_BUS_REQ;
        end else begin
          err_d = 1'b1;  status_d = 2'd3;  idx_d = '0;  bidx_d = '0;  state_d = S_RESP;
        end
      end
      S_BUS_REQ: begin
        ack_d = '0;
        if (AccessGranted) begin
          idx_d   = '0;
          addr_d  = base_q;
          data_d  = mem_q[0];
          state_d = S_BUS_XFER;
        end
      end
      S_BUS_XFER: begin
        if (DataBusStrobe) begin
          ack_d  = '0;
          mem_we = !wcmd_q;
          if (idx_q == cnt_m1_q) begin
            idx_d = '0;  bidx_d = '0;  state_d = S_RESP;
          end else begin
            idx_d  = idx_nx;
            addr_d = addr_q + 1'b1;
            data_d = mem_q[idx_nx];
          end
        end else if (ack_q >= ATW'(ACK_TIMEOUT - 1)) begin
          err_d = 1'b1;  status_d = 2'd1;  idx_d = '0;  bidx_d = '0;  state_d = S_RESP;
        end
      end
      S_RESP: if (wr_ph_q == 3'd4) begin
        case (rsel_q)
          3'd2: rsel_d = (status_q == 2'd0 && !wcmd_q) ? 3'd3 : 3'd4;
          3'd3: begin
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'(NB - 1)) begin
              bidx_d = '0;
              if (idx_q == cnt_m1_q) rsel_d = 3'd4;
              else idx_d = idx_nx;
            end
          end
          3'd5: begin
            rsel_d  = 3'd0;
            state_d = S_HUNT;
          end
          default: rsel_d = rsel_q + 3'd1;
        endcase
      end
      default: state_d = S_HUNT;
    endcase

    // Inter-byte silence inside a packet abandons it without a response
    if (pkt_body && !byte_vld && tmo_q >= BTW'(BYTE_TIMEOUT)) begin
      err_d   = 1'b1;
      state_d = S_HUNT;
    end

    rd_n_d = (rd_ph_d == 2'd0);
    wr_d   = (wr_ph_d == 3'd2) || (wr_ph_d == 3'd3);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HUNT;  rd_ph_q <= '0;  rd_n_q <= 1'b1;  wr_ph_q <= '0;  wr_q <= 1'b0;
      dout_q <= '0;  hdr_q <= 1'b0;  trl_q <= 1'b0;  err_q <= 1'b0;  wcmd_q <= 1'b0;
      status_q <= '0;  rsel_q <= '0;  cnt_m1_q <= '0;  idx_q <= '0;  bidx_q <= '0;
      base_q <= '0;  addr_q <= '0;  wacc_q <= '0;  data_q <= '0;  tmo_q <= '0;  ack_q <= '0;
    end else begin
      state_q <= state_d;  rd_ph_q <= rd_ph_d;  rd_n_q <= rd_n_d;  wr_ph_q <= wr_ph_d;
      wr_q <= wr_d;  dout_q <= dout_d;  hdr_q <= hdr_d;  trl_q <= trl_d;  err_q <= err_d;
      wcmd_q <= wcmd_d;  status_q <= status_d;  rsel_q <= rsel_d;  cnt_m1_q <= cnt_m1_d;
      idx_q <= idx_d;  bidx_q <= bidx_d;  base_q <= base_d;  addr_q <= addr_d;
      wacc_q <= wacc_d;  data_q <= data_d;  tmo_q <= tmo_d;  ack_q <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign FT_RDn             = rd_n_q;
  assign FT_WR              = wr_q;
  assign FT_DATA_Out        = dout_q;
  assign USB_Active         = (state_q != S_HUNT);
  assign Header_recognized  = hdr_q;
  assign Trailer_recognized = trl_q;
  assign Packet_Proc        = !(state_q inside {S_HUNT, S_HDR2, S_CMD});
  assign Error              = err_q;
  assign AccessRequest      = (state_q == S_BUS_REQ) || (state_q == S_BUS_XFER);
  assign DirectOut          = wcmd_q && AccessRequest;
  assign AddrBusOut         = addr_q;
  assign DataBusOut         = data_q;
endmodule

// File: tb/tb_usb_packet_bridge.sv
// Directed bench for usb_packet_bridge: host FIFO and bus slave models, per-scenario tasks.
module tb_usb_packet_bridge;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        FT_RXFn = 1'b1, FT_TXEn = 1'b0, FT_RDn, FT_WR;
  logic [7:0]  FT_DATA_In = 8'h00, FT_DATA_Out;
  logic        USB_Active, Header_recognized, Trailer_recognized, Packet_Proc, Error;
  logic        AccessRequest, AccessGranted = 1'b0, DirectOut, DataBusStrobe = 1'b0;
  logic [15:0] AddrBusOut, DataBusOut, DataBus_In = 16'h0000;

  usb_packet_bridge #(.ADDR_W(16), .DATA_W(16), .BUF_DEPTH(4), .BYTE_TIMEOUT(100),
                      .ACK_TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .FT_RXFn(FT_RXFn), .FT_TXEn(FT_TXEn), .FT_RDn(FT_RDn),
    .FT_WR(FT_WR), .FT_DATA_In(FT_DATA_In), .FT_DATA_Out(FT_DATA_Out),
    .USB_Active(USB_Active), .Header_recognized(Header_recognized),
    .Trailer_recognized(Trailer_recognized), .Packet_Proc(Packet_Proc), .Error(Error),
    .AccessRequest(AccessRequest), .AccessGranted(AccessGranted), .DirectOut(DirectOut),
    .AddrBusOut(AddrBusOut), .DataBusOut(DataBusOut), .DataBus_In(DataBus_In),
    .DataBusStrobe(DataBusStrobe));

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  logic [7:0]  rxq[$], txq[$];
  logic [32:0] wlog[$];
  logic [15:0] rdata [4];
  logic [2:0]  stall_word = 3'd7, widx = 3'd0;
  logic [15:0] stall_addr = 16'h0000;
  int          err_cnt = 0, hdr_cnt = 0, trl_cnt = 0, req_seen = 0, err_wide = 0, stall_cyc = 0;
  logic        err_prev = 1'b0;

  // Host side of the FIFO
  always @(negedge clk) begin
    FT_RXFn    = (rxq.size() == 0);
    FT_DATA_In = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end
  always @(posedge FT_RDn) if (rxq.size() != 0) void'(rxq.pop_front());
  always @(posedge FT_WR) txq.push_back(FT_DATA_Out);

  always @(negedge clk) begin
    if (Error) err_cnt++;
    if (Error && err_prev) err_wide++;
    err_prev = Error;
    if (Header_recognized) hdr_cnt++;
    if (Trailer_recognized) trl_cnt++;
    if (AccessRequest) req_seen++;
    if (AccessRequest && stall_word != 3'd7 && AddrBusOut == stall_addr) stall_cyc++;
  end

  // Bus slave: grant immediately, strobe every other cycle, optionally never ack one word
  always @(negedge clk) begin
    if (!AccessRequest) begin
      AccessGranted = 1'b0;  DataBusStrobe = 1'b0;  widx = 3'd0;
    end else if (!AccessGranted) AccessGranted = 1'b1;
    else if (DataBusStrobe) begin
      DataBusStrobe = 1'b0;  widx = widx + 3'd1;
    end else if (widx != stall_word) begin
      DataBusStrobe = 1'b1;
      DataBus_In    = rdata[widx[1:0]];
      wlog.push_back({DirectOut, AddrBusOut, DataBusOut});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] pack_tx();
    logic [127:0] r = '0;
    foreach (txq[i]) r = {r[119:0], txq[i]};
    return r;
  endfunction

  task automatic clear_mon();
    txq.delete();  wlog.delete();
    err_cnt = 0;  hdr_cnt = 0;  trl_cnt = 0;  req_seen = 0;  err_wide = 0;  stall_cyc = 0;
  endtask

  task automatic wait_idle(input int n, input int maxc);
    int c = 0;
    while ((txq.size() < n || USB_Active) && c < maxc) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    logic [16:0] ctl;
    @(negedge clk);
    ctl = {FT_RDn, FT_WR, FT_DATA_Out, USB_Active, Header_recognized, Trailer_recognized,
           Packet_Proc, Error, AccessRequest, DirectOut};
    total++; if (ctl !== 17'h10000) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", ctl, 17'h10000); end
    total++; if ({AddrBusOut, DataBusOut} !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {AddrBusOut, DataBusOut}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    logic [32:0] ew [3];
    ew[0] = {1'b1, 16'h1234, 16'h0011};
    ew[1] = {1'b1, 16'h1235, 16'h0022};
    ew[2] = {1'b1, 16'h1236, 16'h0033};
    clear_mon();
    rxq = '{8'hA5, 8'h5A, 8'h01, 8'h03, 8'h12, 8'h34, 8'h00, 8'h11, 8'h00, 8'h22,
            8'h00, 8'h33, 8'h5A, 8'hA5};
    wait_idle(5, 600);
    total++; if (wlog.size() != 3) begin bad++; $display("FAIL wr_count got=%0d exp=3", wlog.size()); end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      total++; if (wlog[i] !== ew[i]) begin bad++; $display("FAIL wr_word%0d got=%h exp=%h", i, wlog[i], ew[i]); end
    end
    total++; if (pack_tx() !== 128'hA55A005AA5) begin bad++; $display("FAIL wr_resp got=%h exp=%h", pack_tx(), 128'hA55A005AA5); end
    total++; if ({hdr_cnt, trl_cnt, err_cnt} !== {32'd1, 32'd1, 32'd0}) begin
      bad++; $display("FAIL wr_pulses got=%0d/%0d/%0d exp=1/1/0", hdr_cnt, trl_cnt, err_cnt);
    end
  endtask

  task automatic test_read_wrap();
    clear_mon();
    rdata[0] = 16'hBEEF;  rdata[1] = 16'hCAFE;
    rxq = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h5A, 8'hA5};
    wait_idle(9, 600);
    total++; if (wlog.size() != 2) begin bad++; $display("FAIL rd_count got=%0d exp=2", wlog.size()); end
    else begin
      total++; if (wlog[0][32:16] !== {1'b0, 16'hFFFF}) begin bad++; $display("FAIL rd_addr0 got=%h exp=%h", wlog[0][32:16], {1'b0, 16'hFFFF}); end
      total++; if (wlog[1][32:16] !== {1'b0, 16'h0000}) begin bad++; $display("FAIL rd_addr1_wrap got=%h exp=0", wlog[1][32:16]); end
    end
    total++; if (pack_tx() !== 128'hA55A00BEEFCAFE5AA5) begin bad++; $display("FAIL rd_resp got=%h exp=%h", pack_tx(), 128'hA55A00BEEFCAFE5AA5); end
  endtask

  task automatic test_bad_trailer();
    clear_mon();
    rxq = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h00, 8'h10, 8'hAB, 8'hCD, 8'h5A, 8'hA6};
    wait_idle(5, 600);
    total++; if (req_seen != 0) begin bad++; $display("FAIL trl_no_bus got=%0d exp=0", req_seen); end
    total++; if (err_cnt != 1 || err_wide != 0) begin bad++; $display("FAIL trl_error got=%0d wide=%0d exp=1", err_cnt, err_wide); end
    total++; if (trl_cnt != 0) begin bad++; $display("FAIL trl_pulse got=%0d exp=0", trl_cnt); end
    total++; if (pack_tx() !== 128'hA55A035AA5) begin bad++; $display("FAIL trl_resp got=%h exp=%h", pack_tx(), 128'hA55A035AA5); end
  endtask

  task automatic test_ack_timeout();
    clear_mon();
    stall_word = 3'd2;  stall_addr = 16'h2002;
    rxq = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h20, 8'h00, 8'h5A, 8'hA5};
    wait_idle(5, 2000);
    total++; if (wlog.size() != 2) begin bad++; $display("FAIL ack_words got=%0d exp=2", wlog.size()); end
    total++; if (stall_cyc != 255) begin bad++; $display("FAIL ack_wait_cycles got=%0d exp=255", stall_cyc); end
    total++; if (err_cnt != 1 || err_wide != 0) begin bad++; $display("FAIL ack_error got=%0d wide=%0d exp=1", err_cnt, err_wide); end
    total++; if (pack_tx() !== 128'hA55A015AA5) begin bad++; $display("FAIL ack_resp got=%h exp=%h", pack_tx(), 128'hA55A015AA5); end
    stall_word = 3'd7;
  endtask

  task automatic test_resync_bad_count();
    clear_mon();
    rxq = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h05};
    wait_idle(5, 600);
    total++; if (hdr_cnt != 1) begin bad++; $display("FAIL cnt_hdr got=%0d exp=1", hdr_cnt); end
    total++; if (err_cnt != 1 || req_seen != 0) begin bad++; $display("FAIL cnt_err got=%0d req=%0d exp=1/0", err_cnt, req_seen); end
    total++; if (pack_tx() !== 128'hA55A025AA5) begin bad++; $display("FAIL cnt_resp got=%h exp=%h", pack_tx(), 128'hA55A025AA5); end
    clear_mon();
    rdata[0] = 16'h1234;
    rxq = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h42, 8'h5A, 8'hA5};
    wait_idle(7, 600);
    total++; if (wlog.size() != 1 || wlog[0][32:16] !== {1'b0, 16'h0042}) begin
      bad++; $display("FAIL after_cnt_bus got=%0d words exp=1 at 0042", wlog.size());
    end
    total++; if (pack_tx() !== 128'hA55A0012345AA5) begin bad++; $display("FAIL after_cnt_resp got=%h exp=%h", pack_tx(), 128'hA55A0012345AA5); end
  endtask

  task automatic test_byte_timeout();
    clear_mon();
    rxq = '{8'hA5, 8'h5A, 8'h01};
    repeat (250) @(negedge clk);
    total++; if (err_cnt != 1 || err_wide != 0) begin bad++; $display("FAIL bto_error got=%0d wide=%0d exp=1", err_cnt, err_wide); end
    total++; if (txq.size() != 0 || USB_Active !== 1'b0) begin
      bad++; $display("FAIL bto_idle got=%0d bytes active=%b exp=0/0", txq.size(), USB_Active);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] ctl;
    int c = 0;
    clear_mon();
    rxq = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00, 8'h50, 8'h00, 8'h01};
    while (rxq.size() != 0 && c < 200) begin @(negedge clk); c++; end
    repeat (2) @(negedge clk);
    total++; if (Packet_Proc !== 1'b1) begin bad++; $display("FAIL mid_proc got=%b exp=1", Packet_Proc); end
    reset_n = 1'b0;
    #1;
    ctl = {FT_RDn, FT_WR, FT_DATA_Out, USB_Active, Header_recognized, Trailer_recognized,
           Packet_Proc, Error, AccessRequest, DirectOut};
    total++; if (ctl !== 17'h10000) begin bad++; $display("FAIL mid_reset_ctl got=%h exp=%h", ctl, 17'h10000); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (err_cnt != 0 || txq.size() != 0) begin bad++; $display("FAIL mid_no_err got=%0d/%0d exp=0/0", err_cnt, txq.size()); end
    rxq = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h00, 8'h60, 8'h55, 8'h55, 8'h5A, 8'hA5};
    wait_idle(5, 600);
    total++; if (wlog.size() != 1 || wlog[0] !== {1'b1, 16'h0060, 16'h5555}) begin
      bad++; $display("FAIL mid_next_bus got=%0d words exp=1 of 1_0060_5555", wlog.size());
    end
    total++; if (pack_tx() !== 128'hA55A005AA5) begin bad++; $display("FAIL mid_next_resp got=%h exp=%h", pack_tx(), 128'hA55A005AA5); end
  endtask

  task automatic test_tx_stall();
    int wr_hi = 0;
    clear_mon();
    FT_TXEn  = 1'b1;
    rdata[0] = 16'h9999;
    rxq = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h70, 8'h5A, 8'hA5};
    repeat (200) begin
      @(negedge clk);
      if (FT_WR) wr_hi++;
    end
    total++; if (wr_hi != 0 || txq.size() != 0) begin bad++; $display("FAIL stall_wr got=%0d exp=0", wr_hi); end
    total++; if (USB_Active !== 1'b1) begin bad++; $display("FAIL stall_active got=%b exp=1", USB_Active); end
    FT_TXEn = 1'b0;
    wait_idle(7, 600);
    total++; if (pack_tx() !== 128'hA55A0099995AA5) begin bad++; $display("FAIL stall_resp got=%h exp=%h", pack_tx(), 128'hA55A0099995AA5); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_bad_trailer();
    test_ack_timeout();
    test_resync_bad_count();
    test_byte_timeout();
    test_reset_mid();
    test_tx_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
